stepper_multi_axis_ctrl: RTL and testbench



---
 rtl/stepper_pkg.sv | 14 +
 rtl/stepper_channel.sv | 106 ++++++++++
 rtl/stepper_multi_axis_ctrl.sv | 105 ++++++++++
 tb/tb_stepper_multi_axis_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stepper_pkg.sv
// Shared channel-state encoding for the multi-axis stepper controller.
package stepper_pkg;

    localparam int STATE_W = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_SETUP = 3'd1;
    localparam state_t ST_HIGH  = 3'd2;
    localparam state_t ST_LOW   = 3'd3;
    localparam state_t ST_FIN   = 3'd4;

endpackage

// File: rtl/stepper_channel.sv
// One stepper axis: DIR setup wait, fixed-width STEP pulses at a clamped period, then FIN.
// With STEP_POS_TRACK_EN defined, also exports a one-cycle-early rise strobe for position tracking.
module stepper_channel
    import stepper_pkg::*;
#(
    parameter int STEP_W    = 32,
    parameter int PERIOD_W  = 32,
    parameter int PULSE_W   = 2,
    parameter int DIR_SETUP = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic                clear,
    input  logic [STEP_W-1:0]   cmd_steps,
    input  logic                cmd_dir,
    input  logic [PERIOD_W-1:0] cmd_period,
`ifdef STEP_POS_TRACK_EN
    output logic                rise,
`endif
    output logic                step,
    output logic                dir,
    output logic                fin
);

    localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(PULSE_W + 1);
    localparam logic [PERIOD_W-1:0] PULSE_LAST = PERIOD_W'(PULSE_W - 1);
    localparam logic [PERIOD_W-1:0] SETUP_LAST = PERIOD_W'(DIR_SETUP - 1);
    localparam logic [PERIOD_W-1:0] ONE_TICK   = PERIOD_W'(1);

    // Short periods are stretched so a LOW phase of at least one cycle always separates pulses.
    function automatic logic [PERIOD_W-1:0] clamp_period(input logic [PERIOD_W-1:0] p);
        return (p < MIN_PERIOD) ? MIN_PERIOD : p;
    endfunction

    state_t              state;
    state_t              state_next;
    logic [PERIOD_W-1:0] tick;
    logic [PERIOD_W-1:0] eff_period;
    logic [STEP_W-1:0]   steps_left;
    logic                dir_q;
    logic                enter_high;
    logic                active;

    assign active = (state == ST_SETUP) || (state == ST_HIGH) || (state == ST_LOW);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = (cmd_steps == '0) ? ST_FIN : ST_SETUP;
            ST_SETUP: begin
                if (abort)                     state_next = ST_FIN;
                else if (tick == SETUP_LAST)   state_next = ST_HIGH;
            end
            // abort in HIGH only zeroes the count, so the pulse and its LOW tail still complete
            ST_HIGH:  if (tick == PULSE_LAST) state_next = ST_LOW;
            ST_LOW: begin
                if (abort)                                state_next = ST_FIN;
                else if (tick == eff_period - ONE_TICK)   state_next = (steps_left != '0) ? ST_HIGH : ST_FIN;
            end
            ST_FIN:   if (clear) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        step       = (state == ST_HIGH);
        fin        = (state == ST_FIN);
        enter_high = (state_next == ST_HIGH) && (state != ST_HIGH);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick       <= '0;
            eff_period <= '0;
            steps_left <= '0;
            dir_q      <= 1'b0;
        end else begin
            if (state == ST_IDLE && start) begin
                dir_q      <= cmd_dir;
                steps_left <= cmd_steps;
                eff_period <= clamp_period(cmd_period);
                tick       <= '0;
            end else if (enter_high) begin
                tick       <= '0;
                steps_left <= steps_left - STEP_W'(1);
            end else if (active) begin
                tick <= tick + ONE_TICK;
            end
            if (abort && active) steps_left <= '0;
        end
    end

    assign dir = dir_q;

`ifdef STEP_POS_TRACK_EN
    assign rise = enter_high;
`endif

endmodule

// File: rtl/stepper_multi_axis_ctrl.sv
// Coordinated multi-axis STEP/DIR generator with valid/ready command intake and done/aborted status.
// Optional per-axis signed position counters are built when STEP_POS_TRACK_EN is defined.
module stepper_multi_axis_ctrl
    import stepper_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int STEP_W    = 32,
    parameter int PERIOD_W  = 32,
    parameter int PULSE_W   = 2,
    parameter int DIR_SETUP = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [NUM_CH*STEP_W-1:0]   cmd_steps,
    input  logic [NUM_CH-1:0]          cmd_dir,
    input  logic [NUM_CH*PERIOD_W-1:0] cmd_period,
    input  logic                       abort,
    output logic [NUM_CH-1:0]          step_out,
    output logic [NUM_CH-1:0]          dir_out,
    output logic                       busy,
    output logic                       done,
`ifdef STEP_POS_TRACK_EN
    output logic [NUM_CH*32-1:0]       position,
`endif
    output logic                       aborted
);

    logic              accept;
    logic              all_fin;
    logic              ch_abort;
    logic              ch_clear;
    logic              abort_req;
    logic [NUM_CH-1:0] fin;

    assign cmd_ready = ~busy;
    assign accept    = cmd_valid & ~busy;
    assign all_fin   = &fin;
    assign ch_abort  = abort & busy;
    assign ch_clear  = busy & all_fin;

    // abort is remembered here and only reported once every axis has wound down
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            abort_req <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                busy      <= 1'b1;
                aborted   <= 1'b0;
                abort_req <= 1'b0;
            end else if (busy && all_fin) begin
                busy    <= 1'b0;
                done    <= 1'b1;
                aborted <= abort_req;
            end else if (busy && abort) begin
                abort_req <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
`ifdef STEP_POS_TRACK_EN
        logic              rise;
        logic signed [31:0] pos;
`endif

        stepper_channel #(
            .STEP_W    (STEP_W),
            .PERIOD_W  (PERIOD_W),
            .PULSE_W   (PULSE_W),
            .DIR_SETUP (DIR_SETUP)
        ) u_ch (
            .clock      (clock),
            .reset      (reset),
            .start      (accept),
            .abort      (ch_abort),
            .clear      (ch_clear),
            .cmd_steps  (cmd_steps[i*STEP_W +: STEP_W]),
            .cmd_dir    (cmd_dir[i]),
            .cmd_period (cmd_period[i*PERIOD_W +: PERIOD_W]),
`ifdef STEP_POS_TRACK_EN
            .rise       (rise),
`endif
            .step       (step_out[i]),
            .dir        (dir_out[i]),
            .fin        (fin[i])
        );

`ifdef STEP_POS_TRACK_EN
        // updates on the edge that raises STEP, wrapping modulo 2^32
        always_ff @(posedge clock or posedge reset) begin
            if (reset)     pos <= '0;
            else if (rise) pos <= dir_out[i] ? pos + 32'sd1 : pos - 32'sd1;
        end

        assign position[i*32 +: 32] = pos;
`endif
    end

endmodule

// File: tb/tb_stepper_multi_axis_ctrl.sv
// Scoreboard bench for stepper_multi_axis_ctrl: directed moves queue expected events, a negedge monitor checks them.
module tb_stepper_multi_axis_ctrl;

    localparam int NUM_CH    = 2;
    localparam int STEP_W    = 32;
    localparam int PERIOD_W  = 32;
    localparam int PULSE_W   = 2;
    localparam int DIR_SETUP = 2;

    localparam int K_STATUS = 0;
    localparam int K_POS    = 1;
    localparam int K_RISE   = 2;
    localparam int K_DONE   = 3;

    typedef struct {
        int          kind;
        int          ch;
        int          cyc;
        int          rank;
        logic        e_busy;
        logic [1:0]  e_dir;
        logic        e_ab;
        logic [1:0]  e_step;
        logic [31:0] e_val;
    } ev_t;

    logic                       clock = 1'b0;
    logic                       reset;
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic [NUM_CH*STEP_W-1:0]   cmd_steps;
    logic [NUM_CH-1:0]          cmd_dir;
    logic [NUM_CH*PERIOD_W-1:0] cmd_period;
    logic                       abort;
    logic [NUM_CH-1:0]          step_out;
    logic [NUM_CH-1:0]          dir_out;
    logic                       busy;
    logic                       done;
    logic                       aborted;
`ifdef STEP_POS_TRACK_EN
    logic [NUM_CH*32-1:0]       position;
`endif

    ev_t              q[$];
    int               cyc = 0;
    int               base = 0;
    int               n_pass = 0;
    int               n_total = 0;
    logic [NUM_CH-1:0] prev_step = '0;
    int               hi_cnt[NUM_CH];

    stepper_multi_axis_ctrl #(
        .NUM_CH    (NUM_CH),
        .STEP_W    (STEP_W),
        .PERIOD_W  (PERIOD_W),
        .PULSE_W   (PULSE_W),
        .DIR_SETUP (DIR_SETUP)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_steps  (cmd_steps),
        .cmd_dir    (cmd_dir),
        .cmd_period (cmd_period),
        .abort      (abort),
        .step_out   (step_out),
        .dir_out    (dir_out),
        .busy       (busy),
        .done       (done),
`ifdef STEP_POS_TRACK_EN
        .position   (position),
`endif
        .aborted    (aborted)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void tally(input bit ok, input string msg);
        n_total++;
        if (ok) n_pass++;
        else    $display("FAIL %s", msg);
    endfunction

    function automatic void check(input string name, input longint act, input longint exp);
        tally(act == exp, $sformatf("%s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc));
    endfunction

    function automatic void push(input ev_t e);
        int idx;
        idx = q.size();
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].cyc > e.cyc || (q[i].cyc == e.cyc && q[i].rank > e.rank)) begin
                idx = i;
                break;
            end
        end
        q.insert(idx, e);
    endfunction

    function automatic ev_t mk(input int kind, input int ch, input int rel, input int rank);
        ev_t e;
        e.kind   = kind;
        e.ch     = ch;
        e.cyc    = base + rel;
        e.rank   = rank;
        e.e_busy = 1'b0;
        e.e_dir  = 2'b00;
        e.e_ab   = 1'b0;
        e.e_step = 2'b00;
        e.e_val  = 32'd0;
        return e;
    endfunction

    function automatic void exp_status(input int rel, input logic b, input logic [1:0] d,
                                       input logic ab, input logic [1:0] st);
        ev_t e;
        e = mk(K_STATUS, 0, rel, 0);
        e.e_busy = b;
        e.e_dir  = d;
        e.e_ab   = ab;
        e.e_step = st;
        push(e);
    endfunction

    function automatic void exp_rise(input int ch, input int rel);
        push(mk(K_RISE, ch, rel, 2 + ch));
    endfunction

    function automatic void exp_done(input int rel, input logic ab);
        ev_t e;
        e = mk(K_DONE, 0, rel, 10);
        e.e_ab = ab;
        push(e);
    endfunction

    function automatic void exp_pos(input int rel, input logic [31:0] v);
        ev_t e;
        e = mk(K_POS, 0, rel, 1);
        e.e_val = v;
        push(e);
    endfunction

    function automatic bit observe(input int k, input int c, output ev_t e);
        tally(q.size() > 0, $sformatf("unexpected_event kind%0d ch%0d: got event at cycle %0d, expected none", k, c, cyc));
        if (q.size() == 0) return 1'b0;
        check("event_id", k * 16 + c, q[0].kind * 16 + q[0].ch);
        check("event_cycle", cyc, q[0].cyc);
        if (q[0].kind == k && q[0].ch == c) begin
            e = q.pop_front();
            return 1'b1;
        end
        return 1'b0;
    endfunction

    always @(negedge clock) begin : monitor
        ev_t e;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            check($sformatf("missing_kind%0d_ch%0d_cycle", q[0].kind, q[0].ch), cyc, q[0].cyc);
            void'(q.pop_front());
        end
        while (q.size() > 0 && q[0].cyc == cyc && q[0].kind == K_STATUS) begin
            e = q.pop_front();
            check("busy", busy, e.e_busy);
            check("cmd_ready", cmd_ready, !e.e_busy);
            check("dir_out", dir_out, e.e_dir);
            check("aborted", aborted, e.e_ab);
            check("step_out", step_out, e.e_step);
        end
`ifdef STEP_POS_TRACK_EN
        while (q.size() > 0 && q[0].cyc == cyc && q[0].kind == K_POS) begin
            e = q.pop_front();
            check("position_x", position[31:0], e.e_val);
        end
`endif
        if (reset) begin
            prev_step <= '0;
            for (int i = 0; i < NUM_CH; i++) hi_cnt[i] <= 0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (step_out[i] && !prev_step[i]) void'(observe(K_RISE, i, e));
                if (!step_out[i] && prev_step[i]) check($sformatf("pulse_width_ch%0d", i), hi_cnt[i], PULSE_W);
                hi_cnt[i] <= step_out[i] ? hi_cnt[i] + 1 : 0;
            end
            if (done) begin
                if (observe(K_DONE, 0, e)) check("done_aborted", aborted, e.e_ab);
            end
            prev_step <= step_out;
        end
    end

    task automatic wait_rel(input int rel);
        while (cyc < base + rel) @(negedge clock);
    endtask

    task automatic send(input logic [31:0] sx, input logic [31:0] sy, input logic [31:0] px,
                        input logic [31:0] py, input logic [1:0] d);
        @(negedge clock);
        base       = cyc;
        cmd_steps  = {sy, sx};
        cmd_period = {py, px};
        cmd_dir    = d;
        cmd_valid  = 1'b1;
    endtask

    task automatic run_basic(input bit poke);
        send(3, 5, 10, 4, 2'b01);
        exp_status(1, 1'b1, 2'b01, 1'b0, 2'b00);
        exp_rise(0, 3); exp_rise(0, 13); exp_rise(0, 23);
        exp_rise(1, 3); exp_rise(1, 7); exp_rise(1, 11); exp_rise(1, 15); exp_rise(1, 19);
        exp_status(6, 1'b1, 2'b01, 1'b0, 2'b00);
        exp_status(33, 1'b1, 2'b01, 1'b0, 2'b00);
        exp_done(34, 1'b0);
        exp_status(34, 1'b0, 2'b01, 1'b0, 2'b00);
        wait_rel(1);
        cmd_valid = 1'b0;
        if (poke) begin
            wait_rel(5);
            cmd_steps = {32'd1, 32'd1};
            cmd_dir   = 2'b10;
            cmd_valid = 1'b1;
            wait_rel(6);
            cmd_valid = 1'b0;
        end
        wait_rel(37);
    endtask

    initial begin
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_steps  = '0;
        cmd_dir    = '0;
        cmd_period = '0;
        abort      = 1'b0;
        exp_status(2, 1'b0, 2'b00, 1'b0, 2'b00);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // basic two-axis move, with a command offered while busy
        run_basic(1'b1);

        // period 1 and 0 are clamped to PULSE_W+1
        send(2, 2, 1, 0, 2'b10);
        exp_status(1, 1'b1, 2'b10, 1'b0, 2'b00);
        exp_rise(0, 3); exp_rise(1, 3);
        exp_status(4, 1'b1, 2'b10, 1'b0, 2'b11);
        exp_status(5, 1'b1, 2'b10, 1'b0, 2'b00);
        exp_rise(0, 6); exp_rise(1, 6);
        exp_done(10, 1'b0);
        exp_status(10, 1'b0, 2'b10, 1'b0, 2'b00);
        wait_rel(1);
        cmd_valid = 1'b0;
        wait_rel(12);

        // abort while idle, then a zero-step move
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        send(0, 0, 5, 5, 2'b11);
        exp_status(1, 1'b1, 2'b11, 1'b0, 2'b00);
        exp_done(2, 1'b0);
        exp_status(3, 1'b0, 2'b11, 1'b0, 2'b00);
        wait_rel(1);
        cmd_valid = 1'b0;
        wait_rel(5);

        // abort during a HIGH pulse
        send(100, 100, 10, 10, 2'b00);
        exp_status(1, 1'b1, 2'b00, 1'b0, 2'b00);
        exp_rise(0, 3); exp_rise(1, 3); exp_rise(0, 13); exp_rise(1, 13);
        exp_status(15, 1'b1, 2'b00, 1'b0, 2'b00);
        exp_status(22, 1'b1, 2'b00, 1'b0, 2'b00);
        exp_done(24, 1'b1);
        exp_status(26, 1'b0, 2'b00, 1'b1, 2'b00);
        wait_rel(1);
        cmd_valid = 1'b0;
        wait_rel(14);
        abort = 1'b1;
        wait_rel(15);
        abort = 1'b0;
        wait_rel(28);

        // asynchronous reset while STEP is high
        send(3, 5, 10, 4, 2'b01);
        exp_status(1, 1'b1, 2'b01, 1'b0, 2'b00);
        exp_rise(0, 3); exp_rise(1, 3);
        exp_status(4, 1'b0, 2'b00, 1'b0, 2'b00);
        exp_status(5, 1'b0, 2'b00, 1'b0, 2'b00);
        wait_rel(1);
        cmd_valid = 1'b0;
        wait_rel(3);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        wait_rel(7);

`ifdef STEP_POS_TRACK_EN
        send(3, 0, 3, 3, 2'b01);
        exp_rise(0, 3); exp_rise(0, 6); exp_rise(0, 9);
        exp_pos(3, 32'd1);
        exp_done(13, 1'b0);
        exp_pos(13, 32'd3);
        wait_rel(1);
        cmd_valid = 1'b0;
        wait_rel(15);
        send(5, 0, 3, 3, 2'b00);
        exp_rise(0, 3); exp_rise(0, 6); exp_rise(0, 9); exp_rise(0, 12); exp_rise(0, 15);
        exp_done(19, 1'b0);
        exp_pos(19, 32'hFFFF_FFFE);
        wait_rel(1);
        cmd_valid = 1'b0;
        wait_rel(21);
`endif

        // a full move after the mid-move reset
        run_basic(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
